shake_squeeze: RTL and testbench
================================

# shake_squeeze

Squeeze-phase controller for the SHAKE sponge. It sits directly downstream of the iterative Keccak-p permutation core. It takes a permuted 1600-bit state and emits the rate portion as a stream of 64-bit words over a valid/ready interface. When more output is needed, it re-invokes the permutation core through that core's `en`/`state_in`/`state_out`/`out_valid` interface until the requested word count has been delivered.

## Interface
Parameters:
- `LANE`, 64, lane width in bits; also the output word width
- `LANES`, 25, lanes per state
- `STATE_W`, `LANE*LANES`, state width
- `RATE_LANES`, 21, rate in lanes (21 = SHAKE128, 17 = SHAKE256); legal range 1..LANES
- `LEN_W`, 16, width of the requested-length field

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset; synchronous, active-high.
- `start` in, 1: begin a squeeze; sampled only in IDLE.
- `state_in` in, STATE_W: already-permuted state; captured when `start` is accepted.
- `out_len_words` in, LEN_W: number of 64-bit words to emit; captured with `start`.
- `dout` out, LANE: output word.
- `dout_valid` out, 1: `dout` holds a word.
- `dout_ready` in, 1: sink accepts the word.
- `dout_last` out, 1: the current word is the final word of the request.
- `perm_en` out, 1: one-cycle start pulse to the permutation core.
- `perm_state` out, STATE_W: state sent to the permutation core.
- `perm_result` in, STATE_W: permutation core output.
- `perm_valid` in, 1: permutation core result pulse.
- `busy` out, 1: high in any state other than IDLE.
- `done` out, 1: one-cycle pulse when the request completes.

## Operation
- Lane i of the state is `state[LANE*i +: LANE]`. Lanes are emitted in order i = 0..RATE_LANES-1. Capacity lanes are never emitted.
- Internal registers: `state_reg` (STATE_W), `lane_idx` ($clog2(RATE_LANES) bits), `remaining` (LEN_W bits).
- FSM states are IDLE, EMIT, PERM, WAIT.
- IDLE:
  - `start`=1 and `out_len_words`≠0: `state_reg`←`state_in`, `remaining`←`out_len_words`, `lane_idx`←0, go to EMIT.
  - `start`=1 and `out_len_words`=0: pulse `done` next cycle and stay in IDLE.
- EMIT:
  - `dout` = lane `lane_idx` of `state_reg`, and `dout_valid`=1.
  - `dout_last` = (`remaining`==1).
  - A handshake occurs when `dout_valid` and `dout_ready` are both high.
  - On handshake with `remaining`==1: go to IDLE and pulse `done` next cycle.
  - On handshake otherwise, with `lane_idx`==RATE_LANES-1: `lane_idx`←0, `remaining`−1, go to PERM.
  - On handshake otherwise: `lane_idx`+1, `remaining`−1.
- PERM: `perm_en`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `perm_valid`, `state_reg`←`perm_result` and go to EMIT.
- `perm_state` is driven from `state_reg` continuously.
- `perm_valid` outside WAIT is ignored.
- `start` outside IDLE is ignored.
- `dout` and `dout_last` are held stable while `dout_valid`=1 and `dout_ready`=0. `dout_valid` never drops without a handshake, except on `rst`.
- All counters are unsigned, with no wrap-around: `remaining` never decrements below 1 in EMIT.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `dout_last`=0, `perm_en`=0, `perm_state`=0, `busy`=0, `done`=0. FSM is in IDLE and all internal registers are 0.
- `rst` mid-operation (any state): return to IDLE with the reset values above on the next edge. No `done` pulse.
- `start` accepted at edge t: `dout_valid`=1 from cycle t+1.
- With `dout_ready` held at 1: one word per cycle within a block.
- Block boundary: the handshake on the last rate lane at edge t is followed by
  - `perm_en`=1 in cycle t+1;
  - WAIT from cycle t+2;
  - with `perm_valid` at edge p, the next word is valid in cycle p+1.
- `done`: high in the cycle after the final handshake, for exactly one cycle. `busy` is low in that same cycle, and `start` may be accepted in it.
- Zero-length request: `start` at edge t gives `done`=1 in cycle t+1. `dout_valid` and `perm_en` are never asserted.

## Test plan
- RATE_LANES=21, lane i of `state_in` = i, `out_len_words`=3, `dout_ready`=1: `dout` = 0, 1, 2 on consecutive cycles; `dout_last` only on the word 2; `done` one cycle later; `perm_en` never asserted.
- `out_len_words`=21: words 0..20 are emitted, `dout_last` is on 20, and `perm_en` is never asserted.
- `out_len_words`=22, with a model core returning lane i = 0x100+i, 24 cycles after `perm_en`:
  - after word 20, exactly one `perm_en` pulse;
  - `perm_state` equals the original state at that pulse;
  - word 21 = 0x100 with `dout_last`=1.
- Backpressure with `dout_ready` pattern 1,0,0,1,0,1… and `out_len_words`=5: `dout` is held stable during stalls; the sequence is 0..4; `dout_valid` never drops mid-request.
- `out_len_words`=0: a single `done` pulse one cycle after `start`, with no `dout_valid` and no `perm_en`.
- `rst` asserted during WAIT, then `perm_valid` pulsed:
  - all outputs return to 0 and the `perm_valid` pulse is ignored;
  - a following `start` with `out_len_words`=1 emits lane 0 of the new `state_in`.

Source files
------------

// File: rtl/shake_squeeze.sv
// SHAKE squeeze controller: streams rate lanes of a permuted state as
// 64-bit words, re-running the Keccak-p core whenever a block is exhausted.
module shake_squeeze #(
  parameter int LANE       = 64,
  parameter int LANES      = 25,
  parameter int STATE_W    = LANE*LANES,
  parameter int RATE_LANES = 21,
  parameter int LEN_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  input  logic [LEN_W-1:0]   out_len_words,
  output logic [LANE-1:0]    dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               perm_en,
  output logic [STATE_W-1:0] perm_state,
  input  logic [STATE_W-1:0] perm_result,
  input  logic               perm_valid,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_PERM,
    S_WAIT
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   lane_idx_q, lane_idx_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               done_q, done_d;

  logic [LANE-1:0]    rate_lane [RATE_LANES];
  logic               last_word;
  logic               last_lane;

  for (genvar i = 0; i < RATE_LANES; i++) begin : g_lane
    assign rate_lane[i] = state_q[LANE*i +: LANE];
  end

  assign last_word = (remaining_q == LEN_W'(1));
  assign last_lane = (lane_idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (start && (out_len_words != '0)) begin
          fsm_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (dout_ready) begin
          if (last_word) begin
            fsm_d = S_IDLE;
          end else if (last_lane) begin
            fsm_d = S_PERM;
          end
        end
      end
      S_PERM: fsm_d = S_WAIT;
      S_WAIT: begin
        if (perm_valid) begin
          fsm_d = S_EMIT;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    dout_valid = (fsm_q == S_EMIT);
    dout       = dout_valid ? rate_lane[lane_idx_q] : '0;
    dout_last  = dout_valid && last_word;
    perm_en    = (fsm_q == S_PERM);
    perm_state = state_q;
    busy       = (fsm_q != S_IDLE);
    done       = done_q;
  end

  always_comb begin
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          if (out_len_words != '0) begin
            state_d     = state_in;
            remaining_d = out_len_words;
            lane_idx_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (dout_ready) begin
          if (last_word) begin
            done_d = 1'b1;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
            lane_idx_d  = last_lane ? '0 : lane_idx_q + IDX_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (perm_valid) begin
          state_d = perm_result;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '0;
      lane_idx_q  <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_shake_squeeze.sv
// Directed bench for shake_squeeze: vector table of squeeze requests
// plus hand-written reset-during-WAIT sequence.
module tb_shake_squeeze;

  localparam int LANE    = 64;
  localparam int LANES   = 25;
  localparam int STATE_W = LANE*LANES;
  localparam int RATE    = 21;
  localparam int LEN_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [STATE_W-1:0] state_in;
  logic [LEN_W-1:0]   out_len_words;
  logic [LANE-1:0]    dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_last;
  logic               perm_en;
  logic [STATE_W-1:0] perm_state;
  logic [STATE_W-1:0] perm_result;
  logic               perm_valid;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;

  logic [STATE_W-1:0] orig_st;
  logic [STATE_W-1:0] model_st;
  logic [STATE_W-1:0] alt_st;

  shake_squeeze #(
    .LANE(LANE), .LANES(LANES), .STATE_W(STATE_W),
    .RATE_LANES(RATE), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in),
    .out_len_words(out_len_words), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .perm_en(perm_en),
    .perm_state(perm_state), .perm_result(perm_result),
    .perm_valid(perm_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [15:0] ready_pat;
    int          exp_words;
    int          exp_perms;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic logic [63:0] exp_word(input int k);
    int blk;
    int ln;
    blk = k / RATE;
    ln  = k % RATE;
    return (blk == 0) ? 64'(ln) : 64'(32'h100 + ln);
  endfunction

  task automatic run_vec(input vec_t v);
    int          k;
    int          perms;
    int          ctr;
    bit          fin;
    logic        pv;
    logic        pr;
    logic [63:0] pd;
    logic        pl;
    logic [STATE_W-1:0] ps;
    k = 0; perms = 0; ctr = 0; fin = 0;
    pv = 0; pr = 0; pd = '0; pl = 0;
    state_in      = orig_st;
    out_len_words = LEN_W'(v.len);
    dout_ready    = 1'b0;
    start         = 1'b1;
    step();
    start = 1'b0;
    if (v.len == 0) begin
      chk("zl_done", done, 1);
      chk("zl_valid", dout_valid, 0);
      chk("zl_perm_en", perm_en, 0);
      chk("zl_busy", busy, 0);
      step();
      chk("zl_done_once", done, 0);
      chk("zl_valid2", dout_valid, 0);
      return;
    end
    for (int j = 0; j < 3000 && !fin; j++) begin
      dout_ready = v.ready_pat[j % 16];
      perm_valid = 1'b0;
      if (ctr > 0) begin
        ctr--;
        if (ctr == 0) perm_valid = 1'b1;
      end
      if (j == 0) chk("first_valid", dout_valid, 1);
      if (pv && !pr) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_data", dout, pd);
        chk("stall_last", dout_last, pl);
      end
      if (perm_en) begin
        perms++;
        ctr = 24;
        ps  = (perms == 1) ? orig_st : model_st;
        for (int i = 0; i < LANES; i++)
          chk("perm_state", perm_state[LANE*i +: LANE], ps[LANE*i +: LANE]);
      end
      if (dout_valid && dout_ready) begin
        chk("word", dout, exp_word(k));
        chk("last", dout_last, (k == v.len-1) ? 1 : 0);
        k++;
        if (k == v.len) fin = 1;
      end
      pv = dout_valid; pr = dout_ready; pd = dout; pl = dout_last;
      step();
    end
    perm_valid = 1'b0;
    dout_ready = 1'b0;
    if (!fin) begin
      failures++;
      checks++;
      $display("FAIL timeout words got=%0d exp=%0d", k, v.len);
    end else begin
      chk("done", done, 1);
      chk("busy_at_done", busy, 0);
      chk("valid_at_done", dout_valid, 0);
      step();
      chk("done_once", done, 0);
    end
    chk("perm_count", perms, v.exp_perms);
    chk("word_count", k, v.exp_words);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < LANES; i++) begin
      orig_st[LANE*i +: LANE]  = 64'(i);
      model_st[LANE*i +: LANE] = 64'(32'h100 + i);
      alt_st[LANE*i +: LANE]   = 64'(32'hA0 + i);
    end
    perm_result   = model_st;
    vecs[0] = '{3,  16'hFFFF, 3,  0};
    vecs[1] = '{21, 16'hFFFF, 21, 0};
    vecs[2] = '{22, 16'hFFFF, 22, 1};
    vecs[3] = '{5,  16'h9A69, 5,  0};
    vecs[4] = '{0,  16'hFFFF, 0,  0};
    vecs[5] = '{43, 16'h9A69, 43, 2};

    rst = 1'b1; start = 1'b0; state_in = '0; out_len_words = '0;
    dout_ready = 1'b0; perm_valid = 1'b0;
    step();
    step();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_perm_en", perm_en, 0);
    chk("rst_pstate", 64'(|perm_state), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      run_vec(vecs[v]);
      step();
    end

    // reset while waiting on the permutation core
    state_in = orig_st; out_len_words = 16'd22;
    dout_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int j = 0; j < 100 && !seen; j++) begin
      if (perm_en) seen = 1;
      else step();
    end
    chk("wr_perm_seen", 64'(seen), 1);
    step(); step(); step();
    chk("wr_busy_wait", busy, 1);
    rst = 1'b1;
    step();
    chk("wr_dout", dout, 0);
    chk("wr_valid", dout_valid, 0);
    chk("wr_perm_en", perm_en, 0);
    chk("wr_pstate", 64'(|perm_state), 0);
    chk("wr_busy", busy, 0);
    chk("wr_done", done, 0);
    rst = 1'b0; perm_valid = 1'b1;
    step();
    perm_valid = 1'b0;
    chk("wr_pv_busy", busy, 0);
    chk("wr_pv_valid", dout_valid, 0);
    chk("wr_pv_done", done, 0);
    chk("wr_pv_pstate", 64'(|perm_state), 0);
    state_in = alt_st; out_len_words = 16'd1;
    dout_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("wr_new_valid", dout_valid, 1);
    chk("wr_new_dout", dout, 64'hA0);
    chk("wr_new_last", dout_last, 1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    chk("wr_new_done", done, 1);
    chk("wr_new_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
